// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: streams nibble pairs through one add_4, LSB nibble first.
// Optional signed-overflow flag ovf_o when NIBBLE_SERIAL_ADDER_OVF_EN is defined.

module add_4 (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = {1'b0, x_i} + {1'b0, y_i} + {4'b0000, c_i};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf_o,
`endif
  output logic             busy_o
);
  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_next;
  logic [3:0]       x_sel;
  logic [3:0]       y_sel;
  logic [3:0]       nib_s;
  logic             nib_c;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  // Pick operand nibble k and merge the fresh sum nibble into the accumulator image
  always_comb begin
    x_sel    = '0;
    y_sel    = '0;
    acc_next = acc_q;
    for (int k = 0; k < NIB; k++) begin
      if (cnt == CNT_W'(k)) begin
        x_sel             = a_q[4*k +: 4];
        y_sel             = b_q[4*k +: 4];
        acc_next[4*k +: 4] = nib_s;
      end
    end
  end

  add_4 u_add_4 (
    .x_i (x_sel),
    .y_i (y_sel),
    .c_i (carry_q),
    .s_o (nib_s),
    .c_o (nib_c)
  );

  // Operand and partial-sum storage carry no reset; only control and outputs do
  always_ff @(posedge clk_i) begin
    if (state == IDLE && in_valid_i && in_ready_q) begin
      a_q <= a_i;
      b_q <= b_i;
    end
    if (state == RUN) begin
      acc_q <= acc_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
      c_q         <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i && in_ready_q) begin
            carry_q    <= c_i;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          carry_q <= nib_c;
          if (cnt == LAST) begin
            cnt         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            sum_q       <= acc_next;
            c_q         <= nib_c;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            // carry into MSB equals a^b^sum at the MSB; xor with carry out flags overflow
            ovf_q       <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_next[WIDTH-1] ^ nib_c;
`endif
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign sum_o       = sum_q;
  assign c_o         = c_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule
